hilo_muldiv: RTL and testbench
==============================

// Module: hilo_muldiv
// PURPOSE
//  HI/LO register pair with an integrated multi-cycle multiply/divide engine,
//  parametrised in data width and multiplier latency. Sits beside the execute
//  stage. Accepts MULT/DIV/MTHI/MTLO requests over a valid/ready handshake and
//  writes results into HI/LO. Exposes bypassed next-state HI/LO so MFHI/MFLO in
//  the write cycle read the new value.
// PARAMETERS
//  W          32  data width; product/accumulator width is 2*W
//  MUL_STAGES 2   multiply latency in cycles (>=1), pipelined shift of operands
// PORTS
//  clk        in   1    clock, rising edge
//  resetn     in   1    asynchronous active-low reset
//  req_valid  in   1    request present
//  req_ready  out  1    engine can accept (state==IDLE)
//  req_op     in   4    0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                       7 MADD,8 MADDU,9 MSUB,A MSUBU, others NOP
//  req_a      in   W    operand rs (dividend / MTHI,MTLO data)
//  req_b      in   W    operand rt (divisor)
//  flush      in   1    abort in-flight op / drop same-cycle request
//  busy       out  1    multiply or divide in progress
//  done       out  1    one-cycle pulse: HI/LO written at end of this cycle
//  hi_new     out  W    HI value after this cycle's write (bypass)
//  lo_new     out  W    LO value after this cycle's write (bypass)
// BEHAVIOUR
//  - Reset (async, resetn=0): hi=lo=0, state IDLE, busy=0, done=0,
//    req_ready=1, hi_new=lo_new=0. Reset mid-op abandons op, no write.
//  - Accept = req_valid & req_ready & ~flush. NOP accepted, no effect.
//  - MTHI/MTLO: no state change; hi_new (or lo_new)=req_a combinationally in
//    accept cycle, register updated at that edge; done=0 for these ops.
//  - States IDLE->MUL (mult ops) ->IDLE; IDLE->DIV->IDLE. busy=(state!=IDLE).
//  - MUL: done high in cycle MUL_STAGES after accept cycle; {hi,lo}=a*b (2W,
//    signed for MULT/MADD/MSUB, unsigned for U forms). MADD*: {hi,lo}+=prod,
//    MSUB*: {hi,lo}-=prod, mod 2^(2W), using HI/LO value at done cycle.
//  - DIV: radix-2 restoring on magnitudes, W iterations + 1 sign-fixup cycle;
//    done in cycle W+1 after accept. lo=quotient (trunc toward 0), hi=remainder
//    (sign of dividend). Signed -2^(W-1)/-1: lo=0x8000_0000, hi=0 (W=32).
//  - Divide by zero: done in cycle 1 after accept; lo='1, hi=req_a.
//  - During done cycle hi_new/lo_new show result; state returns IDLE at that
//    edge; req_ready=1 next cycle (no same-cycle back-to-back accept).
//  - flush: any state ->IDLE at next edge, no HI/LO write, done=0 that cycle;
//    flush in the done cycle suppresses the write. flush in IDLE drops request.
//  - Operands latched at accept; req_a/req_b may change afterwards.
// CONFIGURATION
//  HILO_MADD_EN defined: ops 7-A accumulate as above.
//  HILO_MADD_EN undefined: ops 7-A decode as NOP (accepted, no write, done=0);
//    accumulate adder/subtractor not instantiated.
// TESTING
//  1 MTHI a=0x1234 then MTLO a=0x5678 -> hi_new=0x1234 same cycle; after 2
//    cycles hi=0x1234, lo=0x5678, done never high.
//  2 MULT a=0xFFFF_FFFF(-1) b=2, MUL_STAGES=2 -> done in cycle 2,
//    hi=0xFFFF_FFFF lo=0xFFFF_FFFE; MULTU same -> hi=0x1, lo=0xFFFF_FFFE.
//  3 DIV a=-7 b=2 -> done cycle 33, lo=0xFFFF_FFFD(-3), hi=0xFFFF_FFFF(-1);
//    DIVU a=7 b=0 -> done cycle 1, lo=0xFFFF_FFFF, hi=7.
//  4 DIVU started, flush at cycle 10 -> req_ready=1 at cycle 11, hi/lo
//    unchanged, done never high; resetn=0 mid-MUL -> hi=lo=0 immediately.
//  5 HILO_MADD_EN: hi=0,lo=0xFFFF_FFFF, MADDU a=1 b=1 -> hi=1, lo=0;
//    without macro same stimulus -> hi/lo unchanged, done=0.
//  6 req_valid held high during busy -> req_ready=0, no second accept until
//    cycle after done; signed overflow -2^31/-1 -> lo=0x8000_0000, hi=0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply/divide engine and bypassed next-state outputs.
// Optional build macro HILO_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (7-A).
module hilo_muldiv #(
  parameter int W          = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_new,
  output logic [W-1:0] lo_new,
  output logic [1:0]   dbg_state
);

  // Handshake: a request is taken in a cycle where req_valid & req_ready & ~flush;
  // req_ready is high only in IDLE, and operands are captured on that edge.

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [W-1:0]  hi_q, lo_q;
  logic [W-1:0]  op_a_q, op_b_q;
  logic          sgn_q, dzero_q, neg_q_q, neg_r_q;
  logic [W-1:0]  rem_q, quo_q, dvsr_q;
  logic [CW-1:0] cnt_q;

  logic dec_mul, dec_div, dec_signed, dec_mthi, dec_mtlo;
  logic accept;

`ifdef HILO_MADD_EN
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
  logic [1:0] dec_acc, acc_q;
`endif

  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
`ifdef HILO_MADD_EN
    dec_acc    = ACC_NONE;
`endif
    case (req_op)
      4'h1: begin dec_mul = 1'b1; dec_signed = 1'b1; end
      4'h2: dec_mul = 1'b1;
      4'h3: begin dec_div = 1'b1; dec_signed = 1'b1; end
      4'h4: dec_div = 1'b1;
      4'h5: dec_mthi = 1'b1;
      4'h6: dec_mtlo = 1'b1;
`ifdef HILO_MADD_EN
      4'h7: begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_ADD; end
      4'h8: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
      4'h9: begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_SUB; end
      4'hA: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign accept    = resetn & req_valid & req_ready & ~flush;

  // Multiply: sign/zero-extend to 2W so the low 2W product bits are exact either way.
  logic [2*W-1:0] mul_a_ext, mul_b_ext, prod, mul_res;
  assign mul_a_ext = sgn_q ? {{W{op_a_q[W-1]}}, op_a_q} : {{W{1'b0}}, op_a_q};
  assign mul_b_ext = sgn_q ? {{W{op_b_q[W-1]}}, op_b_q} : {{W{1'b0}}, op_b_q};
  assign prod      = mul_a_ext * mul_b_ext;

`ifdef HILO_MADD_EN
  always_comb begin
    case (acc_q)
      ACC_ADD: mul_res = {hi_q, lo_q} + prod;
      ACC_SUB: mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  // Restoring divide on magnitudes; quotient bits shift in from the right of quo_q.
  logic [W:0]   rem_shift, diff;
  logic [W-1:0] quo_fix, rem_fix, mag_a, mag_b;
  assign rem_shift = {rem_q, quo_q[W-1]};
  assign diff      = rem_shift - {1'b0, dvsr_q};
  assign quo_fix   = neg_q_q ? -quo_q : quo_q;
  assign rem_fix   = neg_r_q ? -rem_q : rem_q;
  assign mag_a     = (dec_signed & req_a[W-1]) ? -req_a : req_a;
  assign mag_b     = (dec_signed & req_b[W-1]) ? -req_b : req_b;

  always_comb begin
    state_nxt = state_q;
    done      = 1'b0;
    hi_new    = hi_q;
    lo_new    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_mthi) hi_new = req_a;
          if (dec_mtlo) lo_new = req_a;
          if (dec_mul)      state_nxt = S_MUL;
          else if (dec_div) state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          done             = 1'b1;
          {hi_new, lo_new} = mul_res;
          state_nxt        = S_IDLE;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (dzero_q) begin
          done      = 1'b1;
          hi_new    = op_a_q;
          lo_new    = '1;
          state_nxt = S_IDLE;
        end else if (cnt_q == DIV_LAST) begin
          done      = 1'b1;
          hi_new    = rem_fix;
          lo_new    = quo_fix;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q    <= '0;
      lo_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
      dzero_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
`ifdef HILO_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      // hi_new/lo_new already equal hi_q/lo_q whenever nothing is written.
      hi_q <= hi_new;
      lo_q <= lo_new;
      if (accept) begin
        op_a_q  <= req_a;
        op_b_q  <= req_b;
        sgn_q   <= dec_signed;
        dzero_q <= (req_b == '0);
        neg_q_q <= dec_signed & (req_a[W-1] ^ req_b[W-1]);
        neg_r_q <= dec_signed & req_a[W-1];
        rem_q   <= '0;
        quo_q   <= mag_a;
        dvsr_q  <= mag_b;
        cnt_q   <= '0;
`ifdef HILO_MADD_EN
        acc_q   <= dec_acc;
`endif
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == S_DIV && cnt_q < DIV_LAST) begin
          if (!diff[W]) begin
            rem_q <= diff[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed plus randomised bench for hilo_muldiv: scoreboard queue of expected {hi,lo}
// popped on every done pulse, plus latency and bypass checks.
module tb_hilo_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid, req_ready, flush, busy, done;
  logic [3:0]   req_op;
  logic [W-1:0] req_a, req_b, hi_new, lo_new;
  logic [1:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv #(.W(W), .MUL_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
    .done(done), .hi_new(hi_new), .lo_new(lo_new), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model for HI/LO after one op (W=32).
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = cur;
    case (op)
      4'h1: p = 64'(sa * sb);
      4'h2: p = {32'b0, a} * {32'b0, b};
      4'h3: if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      4'h4: if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
      default: p = cur;
    endcase
    return p;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("done_result", {hi_new, lo_new}, exp_q.pop_front());
    end
  end

  // Drives one request for one cycle; returns 1 ns into cycle 1 after accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    check("ready_at_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'h0; req_a = $urandom; req_b = $urandom;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int n;
    n = 1;
    @(negedge clk);
    while (done !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, 64'(n), 64'(lat));
  endtask

  task automatic read_exp(input string tag, input logic [63:0] e);
    @(negedge clk);
    check(tag, {hi_new, lo_new}, e);
  endtask

  task automatic run_dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] e, input string tag);
    exp_q.push_back(e);
    issue(op, a, b);
    wait_done(lat, {tag, "_lat"});
    {m_hi, m_lo} = e;
    read_exp({tag, "_hilo"}, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int lat;
    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = 4'h0; req_a = '0; req_b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("rst_hilo", {hi_new, lo_new}, 64'd0);
    check("rst_flags", {60'd0, req_ready, busy, done, 1'b0}, {60'd0, 4'b1000});
    @(posedge clk); #1 resetn = 1'b1;

    // MTHI / MTLO bypass, done never pulses (scoreboard flags any)
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 4'h5; req_a = 32'h1234;
    @(negedge clk);
    check("mthi_bypass", {hi_new, lo_new}, {32'h1234, 32'h0});
    @(posedge clk); #1;
    req_op = 4'h6; req_a = 32'h5678;
    @(negedge clk);
    check("mtlo_bypass", {hi_new, lo_new}, {32'h1234, 32'h5678});
    @(posedge clk); #1 req_valid = 1'b0;
    m_hi = 32'h1234; m_lo = 32'h5678;
    read_exp("mt_regs", {32'h1234, 32'h5678});

    run_dir(4'h1, 32'hFFFF_FFFF, 32'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE, "mult_neg");
    run_dir(4'h2, 32'hFFFF_FFFF, 32'd2, 2, 64'h0000_0001_FFFF_FFFE, "multu");
    run_dir(4'h3, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7");
    run_dir(4'h4, 32'd7, 32'd0, 1, 64'h0000_0007_FFFF_FFFF, "divu_zero");
    run_dir(4'h3, 32'hFFFF_FFFB, 32'd0, 1, 64'hFFFF_FFFB_FFFF_FFFF, "div_zero_s");
    run_dir(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, "div_ovf");
    run_dir(4'h4, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu_100_7");

    // Flush a DIVU at cycle 10
    issue(4'h4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_div_busy", {62'd0, busy, done}, {62'd0, 2'b10});
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_div_ready", {62'd0, req_ready, busy}, {62'd0, 2'b10});
    read_exp("flush_div_hilo", {m_hi, m_lo});

    // Flush in the done cycle of a MULT suppresses the write
    issue(4'h1, 32'd9, 32'd9);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_done_cycle", {63'd0, done}, 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    read_exp("flush_mul_hilo", {m_hi, m_lo});

    // Flush in IDLE drops an MTHI
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 4'h5; req_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_bypass", {hi_new, lo_new}, {m_hi, m_lo});
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    read_exp("flush_idle_hilo", {m_hi, m_lo});

    // Request held valid while busy: second accept only in the cycle after done
    exp_q.push_back(64'd42);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 4'h1; req_a = 32'd7; req_b = 32'd6;
    @(negedge clk);
    check("held_c0_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_c1", {61'd0, req_ready, busy, done}, {61'd0, 3'b010});
    @(posedge clk); #1;
    @(negedge clk);
    check("held_c2", {61'd0, req_ready, busy, done}, {61'd0, 3'b011});
    @(posedge clk); #1;
    exp_q.push_back(64'd42);
    @(negedge clk);
    check("held_c3_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1 req_valid = 1'b0; req_op = 4'h0;
    wait_done(2, "held_second_lat");
    m_hi = 32'd0; m_lo = 32'd42;
    read_exp("held_hilo", 64'd42);

    // Accumulate ops
    run_dir(4'h2, 32'hFFFF_FFFF, 32'd1, 2, 64'h0000_0000_FFFF_FFFF, "acc_setup");
`ifdef HILO_MADD_EN
    run_dir(4'h8, 32'd1, 32'd1, 2, 64'h0000_0001_0000_0000, "maddu");
    run_dir(4'h9, 32'd1, 32'd1, 2, 64'h0000_0000_FFFF_FFFF, "msub");
`else
    issue(4'h8, 32'd1, 32'd1);
    repeat (4) @(negedge clk);
    check("maddu_nop_busy", {63'd0, busy}, 64'd0);
    read_exp("maddu_nop_hilo", 64'h0000_0000_FFFF_FFFF);
`endif

    // Randomised MULT/MULTU/DIV/DIVU against the model
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      lat = (op <= 4'h2) ? 2 : ((b == 0) ? 1 : 33);
      run_dir(op, a, b, lat, model(op, a, b, {m_hi, m_lo}), "rand");
    end

    // Reset mid-MUL clears HI/LO immediately
    issue(4'h1, 32'd3, 32'd5);
    resetn = 1'b0;
    #1;
    check("rst_mid_hilo", {hi_new, lo_new}, 64'd0);
    check("rst_mid_flags", {62'd0, req_ready, busy}, {62'd0, 2'b10});
    @(posedge clk); #1 resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (4) @(negedge clk);
    read_exp("rst_mid_after", 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
